alu_param: RTL and testbench
============================

# alu_param

Parametrised accumulator ALU for the CPU datapath, the WIDTH-generic successor of the 8-bit ALU. It holds the accumulator and the result latch, executes the arithmetic, logic, shift and store instructions during EXEC_A, and drives the latch onto the shared data bus during EXEC_B. Compared with the previous generation it adds configurable width, N/V flags, add-with-carry, XOR, shifts that retain the shifted-out bit in C, and a multi-cycle shift-add multiply with a busy handshake to the controller.

## Interface
- WIDTH, 8, datapath width in bits (minimum 4); sets the width of acc, latch and d_bus.
- tclk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- instruction  in  8  instruction register; [7:5] opcode, [4:0] sub-field.
- ldAcc  in  1  on a clock edge, acc <= d_bus.
- useAlu  in  1  on a clock edge, execute the opcode (EXEC_A).
- dbusSelect  in  1  when high, drive latch onto d_bus (EXEC_B).
- acc  out  WIDTH  accumulator.
- latch  out  WIDTH  result latch.
- c, z, n, v  out  1 each  carry/borrow, zero, negative, signed-overflow flags.
- busy  out  1  multiply in progress.
- d_bus  inout  WIDTH  data bus; high-Z when dbusSelect is low.

## Operation
- Reset: acc, latch, c, z, n and v are 0; busy is 0; the multiply sequencer is idle.
- All operations use A = acc (the value before the current edge) and B = d_bus. Every result R is WIDTH bits. Unless stated otherwise: latch <= R, z = (R == 0), n = R[WIDTH-1].
- 000 ADD: {c,R} = A+B; v = signed overflow.
- 001 SUB: {c,R} = A-B with WIDTH+1-bit arithmetic, so c = 1 exactly when A<B (unsigned); v = signed overflow.
- 010 NAND: R = ~(A&B); c = 0; v = 0.
- 011 SHIFT:
  - instruction[4:0] == 5'h1F: logical right shift, R = A>>1, c = A[0].
  - otherwise: left shift, R = A<<1, c = A[WIDTH-1].
  - v = 0 in both cases.
- 100 ADC: {c,R} = A+B+c; v = signed overflow.
- 101 ST: latch <= A; c, z, n and v are unchanged.
- 110 MUL: unsigned multiply, computed by a shift-add sequencer.
  - At the start edge, capture A and B and set busy.
  - On completion, latch <= P[WIDTH-1:0]; c = |P[2WIDTH-1:WIDTH] (high half non-zero); z and n come from the low half; v = 0.
- 111 XOR: R = A^B; c = 0; v = 0.
- ldAcc is honoured on every edge, including while busy. When it is asserted on the same edge as useAlu, the ALU operates on the old acc and acc takes d_bus.
- While busy is high, useAlu is ignored: no change to latch or flags, and no restart.
- The MUL operands are private copies, so changes to acc or d_bus during busy do not affect the product.
- d_bus = dbusSelect ? latch : 'z, combinational, independent of busy.

## Timing
- Single-cycle ops: latch and flags update on the same edge where useAlu=1 is sampled.
- MUL:
  - Edge E0: useAlu=1, opcode 110, busy=0. Operands are captured, busy <= 1, the iteration counter is loaded with WIDTH.
  - Edges E1..E(WIDTH-1): one multiplier bit is processed per edge.
  - Edge E(WIDTH): the last bit is processed, latch and flags are written, and busy <= 0.
  - busy is therefore high for exactly WIDTH cycles. The controller holds in EXEC_A until busy is low.
  - A new useAlu on the edge after E(WIDTH) is accepted.
- Reset asserted mid-multiply aborts it asynchronously: busy=0, and all outputs return to their reset values; no partial product reaches latch.

## Test plan
- ADD and overflow (WIDTH=8):
  - acc=0xF0, d_bus=0x20, ADD -> latch=0x10, c=1, z=0, n=0, v=0.
  - acc=0x7F, d_bus=0x01, ADD -> latch=0x80, c=0, n=1, v=1.
  - With c=1: acc=0x01, d_bus=0x01, ADC -> latch=0x03, c=0.
- SUB:
  - acc=0x05, d_bus=0x05 -> latch=0x00, z=1, c=0.
  - acc=0x03, d_bus=0x05 -> latch=0xFE, c=1, n=1, v=0.
- Shifts:
  - acc=0x81, instruction=0x7F -> latch=0x40, c=1.
  - acc=0x81, instruction=0x60 -> latch=0x02, c=1.
  - ST with acc=0x5A -> latch=0x5A, flags unchanged.
- MUL:
  - acc=0x0C, d_bus=0x0B -> busy high for 8 cycles, then latch=0x84, c=0, z=0.
  - acc=0x20, d_bus=0x10 -> latch=0x00, c=1, z=1.
  - An ADD useAlu pulse at cycle 3 of busy is ignored. ldAcc=1 with d_bus=0x33 at cycle 3 gives acc=0x33 and leaves the product unchanged.
- Reset at cycle 4 of a MUL -> busy=0, acc=latch=0, all flags 0; then dbusSelect=1 drives d_bus=0x00.
- Bus: dbusSelect=0 -> d_bus high-Z; latch=0xA5 with dbusSelect=1 -> d_bus=0xA5. Repeat ADD and MUL with WIDTH=16: 0xFFFF+0x0001 -> latch 0x0000, c=1, z=1.

Source files
------------

// File: rtl/alu_param_if.sv
// Control and status bundle between the CPU controller and the accumulator ALU.
// The shared data bus stays a plain inout port on the ALU because it is
// resolved between several drivers.
interface alu_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic [7:0]       instruction;
    logic             ldAcc;
    logic             useAlu;
    logic             dbusSelect;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] latch;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
    logic             busy;

    // Controller side.
    modport master (
        output instruction, ldAcc, useAlu, dbusSelect,
        input  acc, latch, c, z, n, v, busy
    );

    // ALU side.
    modport slave (
        input  instruction, ldAcc, useAlu, dbusSelect,
        output acc, latch, c, z, n, v, busy
    );
endinterface

// File: rtl/alu_param.sv
// WIDTH-generic accumulator ALU: single-cycle arithmetic/logic/shift/store ops
// plus a shift-add multiplier that holds busy for WIDTH cycles.
module alu_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             tclk,
    input  logic             reset,
    alu_param_if.slave       bus,
    inout  wire [WIDTH-1:0]  d_bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpAdd   = 3'b000;
    localparam logic [2:0] OpSub   = 3'b001;
    localparam logic [2:0] OpNand  = 3'b010;
    localparam logic [2:0] OpShift = 3'b011;
    localparam logic [2:0] OpAdc   = 3'b100;
    localparam logic [2:0] OpSt    = 3'b101;
    localparam logic [2:0] OpMul   = 3'b110;
    localparam logic [2:0] OpXor   = 3'b111;

    typedef enum logic {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   latch_q, latch_d;
    logic               c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [2:0]         opcode;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v, wr_flags;
    logic [2*WIDTH-1:0] prod_step;

    assign opcode = bus.instruction[7:5];
    assign op_a   = acc_q;
    assign op_b   = d_bus;

    // Single-cycle result and flags for the current opcode.
    always_comb begin
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        wr_flags = 1'b1;
        case (opcode)
            OpAdd: begin
                {res_c, res} = {1'b0, op_a} + {1'b0, op_b};
                res_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OpSub: begin
                // Borrow falls out of the extra top bit.
                {res_c, res} = {1'b0, op_a} - {1'b0, op_b};
                res_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OpNand: res = ~(op_a & op_b);
            OpShift: begin
                if (bus.instruction[4:0] == 5'h1F) begin
                    res   = op_a >> 1;
                    res_c = op_a[0];
                end else begin
                    res   = op_a << 1;
                    res_c = op_a[WIDTH-1];
                end
            end
            OpAdc: begin
                {res_c, res} = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, c_q};
                res_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OpSt: begin
                res      = op_a;
                wr_flags = 1'b0;
            end
            OpMul: begin
                // Handled by the sequencer; nothing written here.
                res      = op_a;
                wr_flags = 1'b0;
            end
            default: res = op_a ^ op_b;
        endcase
    end

    // Partial product after folding in the current multiplier bit.
    always_comb begin
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state: accumulator load, single-cycle ops and the multiply sequencer.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        latch_d  = latch_q;
        c_d      = c_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        // ldAcc is honoured in every state, including mid-multiply.
        if (bus.ldAcc) begin
            acc_d = d_bus;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.useAlu) begin
                    if (opcode == OpMul) begin
                        mcand_d  = {{WIDTH{1'b0}}, op_a};
                        mplier_d = op_b;
                        prod_d   = '0;
                        cnt_d    = CntW'(WIDTH);
                        state_d  = StMul;
                    end else begin
                        latch_d = res;
                        if (wr_flags) begin
                            c_d = res_c;
                            z_d = (res == '0);
                            n_d = res[WIDTH-1];
                            v_d = res_v;
                        end
                    end
                end
            end
            StMul: begin
                // useAlu is ignored here; operands are private copies.
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    latch_d = prod_step[WIDTH-1:0];
                    c_d     = |prod_step[2*WIDTH-1:WIDTH];
                    z_d     = (prod_step[WIDTH-1:0] == '0);
                    n_d     = prod_step[WIDTH-1];
                    v_d     = 1'b0;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            latch_q  <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            latch_q  <= latch_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.acc   = acc_q;
    assign bus.latch = latch_q;
    assign bus.c     = c_q;
    assign bus.z     = z_q;
    assign bus.n     = n_q;
    assign bus.v     = v_q;
    assign bus.busy  = (state_q == StMul);

    assign d_bus = bus.dbusSelect ? latch_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_param.sv
// Scoreboard bench for alu_param at WIDTH=8 and WIDTH=16.
module tb_alu_param;
    typedef struct packed {
        logic [15:0] latch;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    logic tclk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    alu_param_if #(.WIDTH(8))  bus8 ();
    alu_param_if #(.WIDTH(16)) bus16 ();

    wire  [7:0]  d8;
    wire  [15:0] d16;
    logic [7:0]  drv8;
    logic [15:0] drv16;
    logic        drv8_en;
    logic        drv16_en;

    assign d8  = drv8_en  ? drv8  : 8'hzz;
    assign d16 = drv16_en ? drv16 : 16'hzzzz;

    alu_param #(.WIDTH(8)) u_dut8 (
        .tclk  (tclk),
        .reset (reset),
        .bus   (bus8.slave),
        .d_bus (d8)
    );

    alu_param #(.WIDTH(16)) u_dut16 (
        .tclk  (tclk),
        .reset (reset),
        .bus   (bus16.slave),
        .d_bus (d16)
    );

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    function automatic exp_t mk(input logic [15:0] l, input logic c, z, n, v);
        exp_t e;
        e.latch = l; e.c = c; e.z = z; e.n = n; e.v = v;
        return e;
    endfunction

    function automatic exp_t obs8();
        return mk({8'h00, bus8.latch}, bus8.c, bus8.z, bus8.n, bus8.v);
    endfunction

    function automatic exp_t obs16();
        return mk(bus16.latch, bus16.c, bus16.z, bus16.n, bus16.v);
    endfunction

    // Reference for the 8-bit add/sub/logic ops using integer arithmetic.
    function automatic exp_t ref8(input logic [2:0] op, input logic [7:0] a, b, input logic cin);
        int s;
        logic [7:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; r = 8'h00;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b); r = 8'(s); c = (s > 255);
                s = int'($signed(a)) + int'($signed(b)); v = (s > 127) || (s < -128);
            end
            3'd1: begin
                r = a - b; c = (a < b);
                s = int'($signed(a)) - int'($signed(b)); v = (s > 127) || (s < -128);
            end
            3'd2: r = ~(a & b);
            3'd4: begin
                s = int'(a) + int'(b) + int'(cin); r = 8'(s); c = (s > 255);
                s = int'($signed(a)) + int'($signed(b)) + int'(cin); v = (s > 127) || (s < -128);
            end
            default: r = a ^ b;
        endcase
        return mk({8'h00, r}, c, (r == 8'h00), r[7], v);
    endfunction

    task automatic load8(input logic [7:0] a);
        @(negedge tclk);
        bus8.ldAcc = 1'b1; drv8 = a; drv8_en = 1'b1;
        @(negedge tclk);
        bus8.ldAcc = 1'b0;
    endtask

    task automatic op8(input logic [7:0] instr, input logic [7:0] b);
        @(negedge tclk);
        bus8.instruction = instr; drv8 = b; drv8_en = 1'b1; bus8.useAlu = 1'b1;
        @(negedge tclk);
        bus8.useAlu = 1'b0;
    endtask

    task automatic load16(input logic [15:0] a);
        @(negedge tclk);
        bus16.ldAcc = 1'b1; drv16 = a; drv16_en = 1'b1;
        @(negedge tclk);
        bus16.ldAcc = 1'b0;
    endtask

    task automatic op16(input logic [7:0] instr, input logic [15:0] b);
        @(negedge tclk);
        bus16.instruction = instr; drv16 = b; drv16_en = 1'b1; bus16.useAlu = 1'b1;
        @(negedge tclk);
        bus16.useAlu = 1'b0;
    endtask

    // Counts negedges with busy high, bounded; called right after the start edge.
    task automatic wait_idle8(output int cyc);
        cyc = 0;
        while (bus8.busy && cyc < 64) begin
            cyc++;
            @(negedge tclk);
        end
    endtask

    task automatic wait_idle16(output int cyc);
        cyc = 0;
        while (bus16.busy && cyc < 64) begin
            cyc++;
            @(negedge tclk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus8.acc, bus8.latch, bus8.c, bus8.z, bus8.n, bus8.v, bus8.busy} !== '0) begin
            errors++;
            $display("FAIL reset8 got acc=%h latch=%h czvn=%b%b%b%b busy=%b want all 0",
                     bus8.acc, bus8.latch, bus8.c, bus8.z, bus8.n, bus8.v, bus8.busy);
        end
        checks++;
        if ({bus16.acc, bus16.latch, bus16.c, bus16.z, bus16.n, bus16.v, bus16.busy} !== '0) begin
            errors++;
            $display("FAIL reset16 got acc=%h latch=%h busy=%b want all 0",
                     bus16.acc, bus16.latch, bus16.busy);
        end
    endtask

    task automatic test_add();
        logic [7:0] ta [3] = '{8'h7F, 8'hF0, 8'h01};
        logic [7:0] tb [3] = '{8'h01, 8'h20, 8'h01};
        logic [7:0] ti [3] = '{8'h00, 8'h00, 8'h80};
        exp_t te [3];
        exp_t e, o;
        te[0] = mk(16'h0080, 1'b0, 1'b0, 1'b1, 1'b1);
        te[1] = mk(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        te[2] = mk(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            load8(ta[i]);
            sbq.push_back(te[i]);
            op8(ti[i], tb[i]);
            e = sbq.pop_front(); o = obs8();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL add[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0] ta [2] = '{8'h05, 8'h03};
        logic [7:0] tb [2] = '{8'h05, 8'h05};
        exp_t te [2];
        exp_t e, o;
        te[0] = mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        te[1] = mk(16'h00FE, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            load8(ta[i]);
            sbq.push_back(te[i]);
            op8(8'h20, tb[i]);
            e = sbq.pop_front(); o = obs8();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sub[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_shift_store();
        logic [7:0] ta [3] = '{8'h81, 8'h81, 8'h5A};
        logic [7:0] ti [3] = '{8'h7F, 8'h60, 8'hA0};
        exp_t te [3];
        exp_t e, o;
        te[0] = mk(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0);
        te[1] = mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        te[2] = mk(16'h005A, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            load8(ta[i]);
            sbq.push_back(te[i]);
            op8(ti[i], 8'h00);
            e = sbq.pop_front(); o = obs8();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL shift_st[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_mul();
        logic [7:0] ta [2] = '{8'h0C, 8'h20};
        logic [7:0] tb [2] = '{8'h0B, 8'h10};
        exp_t te [2];
        exp_t e, o;
        int cyc;
        te[0] = mk(16'h0084, 1'b0, 1'b0, 1'b1, 1'b0);
        te[1] = mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            load8(ta[i]);
            sbq.push_back(te[i]);
            op8(8'hC0, tb[i]);
            wait_idle8(cyc);
            checks++;
            if (cyc != 8) begin
                errors++;
                $display("FAIL mul_busy[%0d] got %0d cycles want 8", i, cyc);
            end
            e = sbq.pop_front(); o = obs8();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mul[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_mul_interference();
        exp_t e, o;
        int cyc;
        load8(8'h0C);
        sbq.push_back(mk(16'h0084, 1'b0, 1'b0, 1'b1, 1'b0));
        op8(8'hC0, 8'h0B);
        cyc = 0;
        while (bus8.busy && cyc < 64) begin
            cyc++;
            if (cyc == 3) begin
                bus8.instruction = 8'h00; bus8.useAlu = 1'b1; bus8.ldAcc = 1'b1; drv8 = 8'h33;
            end else begin
                bus8.useAlu = 1'b0; bus8.ldAcc = 1'b0; drv8 = 8'hEE;
            end
            @(negedge tclk);
        end
        bus8.useAlu = 1'b0; bus8.ldAcc = 1'b0;
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL mul_intf_busy got %0d cycles want 8", cyc);
        end
        e = sbq.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL mul_intf got %h want %h", o, e);
        end
        checks++;
        if (bus8.acc !== 8'h33) begin
            errors++;
            $display("FAIL mul_intf_acc got %h want 33", bus8.acc);
        end
        // New op on the very next edge after completion is accepted.
        sbq.push_back(mk(16'h0034, 1'b0, 1'b0, 1'b0, 1'b0));
        bus8.instruction = 8'h00; drv8 = 8'h01; bus8.useAlu = 1'b1;
        @(negedge tclk);
        bus8.useAlu = 1'b0;
        e = sbq.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL mul_next_op got %h want %h", o, e);
        end
    endtask

    task automatic test_reset_mid_mul();
        load8(8'h0C);
        op8(8'hC0, 8'h0B);
        repeat (3) @(negedge tclk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus8.acc, bus8.latch, bus8.c, bus8.z, bus8.n, bus8.v, bus8.busy} !== '0) begin
            errors++;
            $display("FAIL mid_mul_reset got acc=%h latch=%h busy=%b want all 0",
                     bus8.acc, bus8.latch, bus8.busy);
        end
        @(negedge tclk);
        reset = 1'b0;
        drv8_en = 1'b0;
        bus8.dbusSelect = 1'b1;
        #1;
        checks++;
        if (d8 !== 8'h00) begin
            errors++;
            $display("FAIL mid_mul_bus got %h want 00", d8);
        end
        repeat (12) @(negedge tclk);
        checks++;
        if ({bus8.latch, bus8.busy} !== 9'h000) begin
            errors++;
            $display("FAIL mid_mul_late got latch=%h busy=%b want 00/0", bus8.latch, bus8.busy);
        end
        bus8.dbusSelect = 1'b0;
    endtask

    task automatic test_bus();
        exp_t e, o;
        load8(8'hA5);
        sbq.push_back(mk(16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0));
        op8(8'hA0, 8'h00);
        e = sbq.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL bus_st got %h want %h", o, e);
        end
        bus8.dbusSelect = 1'b0; drv8 = 8'h3C; drv8_en = 1'b1;
        #1;
        checks++;
        if (d8 !== 8'h3C) begin
            errors++;
            $display("FAIL bus_release got %h want 3c", d8);
        end
        drv8_en = 1'b0; bus8.dbusSelect = 1'b1;
        #1;
        checks++;
        if (d8 !== 8'hA5) begin
            errors++;
            $display("FAIL bus_drive got %h want a5", d8);
        end
        // B taken from the bus while the ALU drives it: A5 + A5.
        sbq.push_back(mk(16'h004A, 1'b1, 1'b0, 1'b0, 1'b1));
        @(negedge tclk);
        bus8.instruction = 8'h00; bus8.useAlu = 1'b1;
        @(negedge tclk);
        bus8.useAlu = 1'b0;
        e = sbq.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL bus_add got %h want %h", o, e);
        end
        bus8.dbusSelect = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd7};
        logic [7:0] ma, b;
        logic [2:0] op;
        logic mc;
        exp_t e, o;
        ma = 8'h3C; mc = 1'b0;
        load8(ma);
        for (int i = 0; i < 24; i++) begin
            @(negedge tclk);
            if (i > 0) begin
                e = sbq.pop_front(); o = obs8();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b[%0d] got %h want %h", i - 1, o, e);
                end
            end
            op = (i == 0) ? 3'd7 : ops[$urandom_range(0, 4)];
            b = 8'($urandom);
            e = ref8(op, ma, b, mc);
            sbq.push_back(e);
            mc = e.c;
            ma = b;
            bus8.instruction = {op, 5'h00}; drv8 = b; drv8_en = 1'b1;
            bus8.ldAcc = 1'b1; bus8.useAlu = 1'b1;
        end
        @(negedge tclk);
        bus8.ldAcc = 1'b0; bus8.useAlu = 1'b0;
        e = sbq.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b[23] got %h want %h", o, e);
        end
        checks++;
        if (bus8.acc !== ma) begin
            errors++;
            $display("FAIL b2b_acc got %h want %h", bus8.acc, ma);
        end
    endtask

    task automatic test_wide();
        logic [15:0] ta [3] = '{16'hFFFF, 16'h0123, 16'h00FF};
        logic [15:0] tb [3] = '{16'h0001, 16'h0100, 16'h00FF};
        logic [7:0]  ti [3] = '{8'h00, 8'hC0, 8'hC0};
        exp_t te [3];
        exp_t e, o;
        int cyc;
        te[0] = mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        te[1] = mk(16'h2300, 1'b1, 1'b0, 1'b0, 1'b0);
        te[2] = mk(16'hFE01, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            load16(ta[i]);
            sbq.push_back(te[i]);
            op16(ti[i], tb[i]);
            if (ti[i] == 8'hC0) begin
                wait_idle16(cyc);
                checks++;
                if (cyc != 16) begin
                    errors++;
                    $display("FAIL wide_busy[%0d] got %0d cycles want 16", i, cyc);
                end
            end
            e = sbq.pop_front(); o = obs16();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wide[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus8.instruction = 8'h00; bus8.ldAcc = 1'b0; bus8.useAlu = 1'b0; bus8.dbusSelect = 1'b0;
        bus16.instruction = 8'h00; bus16.ldAcc = 1'b0; bus16.useAlu = 1'b0;
        bus16.dbusSelect = 1'b0;
        drv8 = 8'h00; drv8_en = 1'b0; drv16 = 16'h0000; drv16_en = 1'b0;
        #12;
        test_reset();
        @(negedge tclk);
        reset = 1'b0;
        test_add();
        test_sub();
        test_shift_store();
        test_mul();
        test_mul_interference();
        test_reset_mid_mul();
        test_bus();
        test_back_to_back();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
